// File: rtl/floo_mcast_fork.sv
// Multicast fork: presents one upstream flit to every port in a multi-hot route
// mask and consumes it once every selected port has taken it.
module floo_mcast_fork #(
   parameter int unsigned NumRoutes    = 5,
   parameter type         flit_t       = logic,
   parameter int unsigned DropCntWidth = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  flit_t                         data_i,
   input  logic [NumRoutes-1:0]          route_sel_i,
   output logic [NumRoutes-1:0]          valid_o,
   input  logic [NumRoutes-1:0]          ready_i,
   output flit_t [NumRoutes-1:0]         data_o,
   output logic                          busy_o,
   output logic [DropCntWidth-1:0]       drop_cnt_o
);

   logic [NumRoutes-1:0]    sent_q;
   logic [NumRoutes-1:0]    sent_d;
   logic [NumRoutes-1:0]    done;
   logic [DropCntWidth-1:0] drop_cnt_q;
   logic [DropCntWidth-1:0] drop_cnt_d;
   logic                    drop;

   always_comb begin
      for (int i = 0; i < NumRoutes; i++) begin
         data_o[i] = data_i;
      end
   end

   // valid_o depends only on upstream and local state, never on ready_i
   assign valid_o = {NumRoutes{valid_i}} & route_sel_i & ~sent_q;
   assign done    = ~route_sel_i | sent_q | ready_i;
   assign ready_o = valid_i & (&done);
   assign busy_o  = |sent_q;
   assign drop    = valid_i & (route_sel_i == '0);

   assign drop_cnt_o = drop_cnt_q;

   always_comb begin
      sent_d     = sent_q;
      drop_cnt_d = drop_cnt_q;
      if (valid_i) begin
         if (ready_o) begin
            sent_d = '0;
         end else begin
            sent_d = sent_q | (valid_o & ready_i);
         end
      end
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sent_q     <= '0;
         drop_cnt_q <= '0;
      end else begin
         sent_q     <= sent_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

`ifndef TARGET_SYNTHESIS
   // Upstream must hold the mask while a flit is partially delivered
   logic [NumRoutes-1:0] route_sel_q;

   always_ff @(posedge clk_i) begin
      route_sel_q <= route_sel_i;
      if (busy_o && (route_sel_i != route_sel_q)) begin
         $warning("floo_mcast_fork: route_sel_i changed during partial delivery");
      end
   end
`endif

endmodule

// File: tb/tb_floo_mcast_fork.sv
// Directed and randomized-ready checks for floo_mcast_fork.
module tb_floo_mcast_fork;

   localparam int N = 5;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            valid_i;
   logic            ready_o;
   logic [7:0]      data_i;
   logic [N-1:0]    route_sel_i;
   logic [N-1:0]    valid_o;
   logic [N-1:0]    ready_i;
   logic [N-1:0][7:0] data_o;
   logic            busy_o;
   logic [2:0]      drop_cnt_o;

   int errors = 0;
   int checks = 0;

   floo_mcast_fork #(
      .NumRoutes   (N),
      .flit_t      (logic [7:0]),
      .DropCntWidth(3)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .data_i     (data_i),
      .route_sel_i(route_sel_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .data_o     (data_o),
      .busy_o     (busy_o),
      .drop_cnt_o (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   logic [N-1:0] sel;
   logic [N-1:0] dlv;
   logic [7:0]   flit;
   logic         fin;
   logic         exp_rdy;
   int           cnt0, cnt1, cons;

   initial begin
      rst_ni      = 1'b0;
      valid_i     = 1'b0;
      data_i      = '0;
      route_sel_i = '0;
      ready_i     = '0;
      #4;
      check("rst_valid", valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_drop", drop_cnt_o, 0);
      check("rst_ready", ready_o, 0);
      cyc();
      rst_ni = 1'b1;

      // unicast
      cyc();
      valid_i = 1; route_sel_i = 5'b00100; ready_i = '1; data_i = 8'h3c;
      #3;
      check("uni_valid", valid_o, 5'b00100);
      check("uni_ready", ready_o, 1);
      check("uni_busy", busy_o, 0);
      check("uni_data", data_o[2], 8'h3c);
      cyc();
      valid_i = 0;
      #3;
      check("uni_busy_after", busy_o, 0);

      // staggered multicast
      cyc();
      valid_i = 1; route_sel_i = 5'b10001; ready_i = 5'b00001; data_i = 8'ha5;
      #3;
      check("stg_c0_valid", valid_o, 5'b10001);
      check("stg_c0_ready", ready_o, 0);
      check("stg_c0_busy", busy_o, 0);
      for (int c = 1; c < 3; c++) begin
         cyc();
         ready_i = '0;
         #3;
         check("stg_mid_valid", valid_o, 5'b10000);
         check("stg_mid_ready", ready_o, 0);
         check("stg_mid_busy", busy_o, 1);
      end
      cyc();
      ready_i = 5'b10000;
      #3;
      check("stg_c3_ready", ready_o, 1);
      check("stg_c3_busy", busy_o, 1);
      check("stg_c3_data", data_o[4], 8'ha5);
      cyc();
      valid_i = 0; ready_i = '0;
      #3;
      check("stg_c4_busy", busy_o, 0);

      // drop with all-zero mask, then saturation
      for (int c = 0; c < 3; c++) begin
         cyc();
         valid_i = 1; route_sel_i = '0;
         #3;
         check("drop_ready", ready_o, 1);
         check("drop_valid", valid_o, 0);
      end
      cyc();
      valid_i = 0;
      #3;
      check("drop_cnt3", drop_cnt_o, 3);
      for (int c = 0; c < 6; c++) begin
         cyc();
         valid_i = 1; route_sel_i = '0;
      end
      cyc();
      valid_i = 0;
      #3;
      check("drop_sat", drop_cnt_o, 7);

      // back-to-back
      cnt0 = 0; cnt1 = 0; cons = 0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         valid_i = 1; route_sel_i = 5'b00011; ready_i = '1;
         data_i = 8'(8'h40 + k);
         #3;
         check("b2b_ready", ready_o, 1);
         check("b2b_data1", data_o[1], 8'(8'h40 + k));
         cnt0 += int'(valid_o[0] & ready_i[0]);
         cnt1 += int'(valid_o[1] & ready_i[1]);
         cons += int'(ready_o);
      end
      cyc();
      valid_i = 0;
      #3;
      check("b2b_cons", cons, 8);
      check("b2b_port0", cnt0, 8);
      check("b2b_port1", cnt1, 8);
      check("b2b_busy", busy_o, 0);

      // reset mid-flit
      cyc();
      valid_i = 1; route_sel_i = 5'b00110; ready_i = 5'b00010; data_i = 8'h77;
      #3;
      check("rmf_c0_valid", valid_o, 5'b00110);
      check("rmf_c0_ready", ready_o, 0);
      cyc();
      ready_i = '0;
      #3;
      check("rmf_c1_busy", busy_o, 1);
      check("rmf_c1_valid", valid_o, 5'b00100);
      #1;
      rst_ni = 0;
      #1;
      check("rmf_rst_busy", busy_o, 0);
      check("rmf_rst_drop", drop_cnt_o, 0);
      cyc();
      #3;
      rst_ni = 1;
      #1;
      check("rmf_rel_valid", valid_o, 5'b00110);
      check("rmf_rel_busy", busy_o, 0);
      cyc();
      ready_i = '1;
      #3;
      check("rmf_done", ready_o, 1);
      cyc();
      valid_i = 0;

      // randomized ready with a delivery scoreboard
      for (int f = 0; f < 1000; f++) begin
         cyc();
         sel  = 5'($urandom_range(1, 31));
         flit = 8'($urandom);
         valid_i = 1; route_sel_i = sel; data_i = flit;
         dlv = '0;
         fin = 0;
         for (int c = 0; c < 100 && !fin; c++) begin
            if (c > 0) cyc();
            ready_i = 5'($urandom);
            #3;
            check("rnd_valid", valid_o, sel & ~dlv);
            check("rnd_once", valid_o & ready_i & (dlv | ~sel), 0);
            exp_rdy = &(~sel | dlv | ready_i);
            check("rnd_ready", ready_o, exp_rdy);
            for (int i = 0; i < N; i++) begin
               if (valid_o[i]) check("rnd_data", data_o[i], flit);
            end
            dlv = dlv | (valid_o & ready_i);
            if (ready_o) begin
               check("rnd_all", dlv, sel);
               fin = 1;
            end
         end
         check("rnd_timeout", fin, 1);
      end
      cyc();
      valid_i = 0;
      #3;
      check("end_busy", busy_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
